// File: rtl/clock_gate_ctrl.sv
// Per-domain clock gate sequencing with wake-up/idle hysteresis and a
// round-robin wake arbiter that lets only one domain ramp its clock tree at a time.

module clock_gate_dom #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic req,
  input  logic grant,
  output logic en,
  output logic ok,
  output logic in_wake,
  output logic in_off
);
  typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_IDLE} st_t;

  st_t              state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state <= S_OFF;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_OFF: if (grant && req) begin
        state_nxt = S_WAKE;
        cnt_nxt   = CNT_W'(WAKE_CYCLES - 1);
      end
      // a wake always runs to completion, whatever req does meanwhile
      S_WAKE: if (cnt == '0) state_nxt = S_ON;
              else           cnt_nxt   = cnt - 1'b1;
      S_ON: if (!req) begin
        state_nxt = S_IDLE;
        cnt_nxt   = CNT_W'(IDLE_CYCLES - 1);
      end
      S_IDLE: if (req)             state_nxt = S_ON;
              else if (cnt == '0)  state_nxt = S_OFF;
              else                 cnt_nxt   = cnt - 1'b1;
      default: state_nxt = S_OFF;
    endcase
  end

  assign en      = (state != S_OFF);
  assign ok      = (state == S_ON) || (state == S_IDLE);
  assign in_wake = (state == S_WAKE);
  assign in_off  = (state == S_OFF);
endmodule

module clock_gate_ctrl #(
  parameter int N_DOM       = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [N_DOM-1:0] req,
  input  logic             force_on,
  output logic [N_DOM-1:0] gate_en,
  output logic [N_DOM-1:0] clk_ok,
  output logic             busy
);
  localparam int CNT_MAX = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RR_W    = $clog2(N_DOM);

  logic [N_DOM-1:0] en, wake, off, grant, cand;
  logic [RR_W-1:0]  rr, gnt_idx;
  logic             gnt_vld;

  assign cand = off & req;

  // one grant per cycle, and only while no domain is mid-wake
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!(|wake)) begin
      for (int k = 0; k < N_DOM; k++) begin
        idx = (int'(rr) + k) % N_DOM;
        if (!gnt_vld && cand[idx]) begin
          gnt_vld    = 1'b1;
          gnt_idx    = RR_W'(idx);
          grant[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n)       rr <= '0;
    else if (gnt_vld) rr <= (gnt_idx == RR_W'(N_DOM - 1)) ? '0 : gnt_idx + 1'b1;
  end

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    clock_gate_dom #(
      .WAKE_CYCLES(WAKE_CYCLES),
      .IDLE_CYCLES(IDLE_CYCLES),
      .CNT_W      (CNT_W)
    ) u_dom (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .req    (req[i]),
      .grant  (grant[i]),
      .en     (en[i]),
      .ok     (clk_ok[i]),
      .in_wake(wake[i]),
      .in_off (off[i])
    );
  end

  assign gate_en = en | {N_DOM{force_on}};
  assign busy    = |en;
endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Randomized and directed bench for clock_gate_ctrl against a timestamp-based
// behavioural model of the domain sequencing and round-robin arbitration.

module tb_clock_gate_ctrl;
  localparam int N = 4;
  localparam int W = 2;
  localparam int I = 8;
  localparam int M_OFF = 0, M_WAKE = 1, M_ON = 2, M_IDLE = 3;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         force_on;
  logic [N-1:0] gate_en, clk_ok;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  int ms   [N];
  int wend [N];
  int iend [N];
  int rr_m;
  int cyc = 0;

  clock_gate_ctrl #(.N_DOM(N), .WAKE_CYCLES(W), .IDLE_CYCLES(I)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .req     (req),
    .force_on(force_on),
    .gate_en (gate_en),
    .clk_ok  (clk_ok),
    .busy    (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Model: wake/idle expiry kept as absolute edge numbers, not counters.
  task automatic model_edge();
    int g;
    bit wk;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) ms[i] = M_OFF;
      rr_m = 0;
      return;
    end
    wk = 0;
    for (int i = 0; i < N; i++) if (ms[i] == M_WAKE) wk = 1;
    g = -1;
    if (!wk)
      for (int k = 0; k < N; k++)
        if (g < 0 && ms[(rr_m + k) % N] == M_OFF && req[(rr_m + k) % N]) g = (rr_m + k) % N;
    for (int i = 0; i < N; i++) begin
      case (ms[i])
        M_OFF:  if (i == g) begin ms[i] = M_WAKE; wend[i] = cyc + W; end
        M_WAKE: if (cyc == wend[i]) ms[i] = M_ON;
        M_ON:   if (!req[i]) begin ms[i] = M_IDLE; iend[i] = cyc + I; end
        default: if (req[i]) ms[i] = M_ON;
                 else if (cyc == iend[i]) ms[i] = M_OFF;
      endcase
    end
    if (g >= 0) rr_m = (g + 1) % N;
  endtask

  task automatic tick();
    logic [N-1:0] eg, eo;
    int nw;
    @(posedge clk_in);
    model_edge();
    #1;
    eg = '0; eo = '0;
    for (int i = 0; i < N; i++) begin
      eg[i] = (ms[i] != M_OFF) | force_on;
      eo[i] = (ms[i] == M_ON) || (ms[i] == M_IDLE);
    end
    chk("gate_en", 32'(gate_en), 32'(eg));
    chk("clk_ok", 32'(clk_ok), 32'(eo));
    chk("busy", 32'(busy), 32'(|(eg & ~{N{force_on}}) | (force_on & (eo != 0 || ms.sum() != 0))));
    nw = 0;
    if (!force_on) for (int i = 0; i < N; i++) nw += int'(gate_en[i] & ~clk_ok[i]);
    chk("one_wake", 32'(nw <= 1), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; force_on = 1'b0;
    for (int i = 0; i < N; i++) begin ms[i] = M_OFF; wend[i] = 0; iend[i] = 0; end
    rr_m = 0;
    tick(); tick();
    chk("rst_gate", 32'(gate_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // single domain wake latency
    repeat (9) tick();
    req = 4'b0001;
    tick();
    chk("wake_gate", 32'(gate_en[0]), 32'd1);
    repeat (W - 1) begin tick(); chk("wake_ok_early", 32'(clk_ok[0]), 32'd0); end
    tick();
    chk("wake_ok", 32'(clk_ok[0]), 32'd1);
    repeat (3) tick();

    // hysteresis expiry
    req = '0;
    tick();
    repeat (I - 1) begin tick(); chk("idle_hold", 32'(gate_en[0]), 32'd1); end
    tick();
    chk("idle_off", 32'(gate_en[0]), 32'd0);

    // hysteresis rescue
    req = 4'b0001;
    repeat (W + 2) tick();
    req = '0;
    repeat (4) tick();
    req = 4'b0001;
    repeat (I + 2) begin tick(); chk("rescue_gate", 32'(gate_en[0]), 32'd1); end

    // simultaneous requests: grant order 0,1,2,3 every W+1 edges
    req = '0;
    do_reset();
    req = 4'b1111;
    for (int d = 0; d < N; d++) begin
      tick();
      chk("rr_order", 32'(gate_en), 32'((1 << (d + 1)) - 1));
      repeat (W) tick();
    end
    repeat (4) tick();

    // rr parked at 2 -> domain 2 wins over domain 0
    req = '0;
    do_reset();
    req = 4'b0010;
    repeat (W + 1) tick();
    req = 4'b0101;
    tick();
    chk("rr_first", 32'(gate_en & 4'b0101), 32'h4);
    repeat (W + 1) tick();
    chk("rr_second", 32'(gate_en & 4'b0101), 32'h5);

    // force_on override
    req = '0;
    do_reset();
    force_on = 1'b1;
    #1;
    chk("force_gate", 32'(gate_en), 32'hf);
    chk("force_ok", 32'(clk_ok), 32'd0);
    chk("force_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    force_on = 1'b0;
    #1;
    chk("force_drop", 32'(gate_en), 32'd0);

    // reset with domain 0 idling and domain 1 waking
    req = 4'b0001;
    repeat (W + 2) tick();
    req = 4'b0010;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_gate", 32'(gate_en), 32'd0);
    chk("mid_rst_ok", 32'(clk_ok), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    req = 4'b1111;
    tick();
    chk("mid_rst_rr", 32'(gate_en), 32'd1);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      force_on = ($urandom_range(0, 15) == 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
